gobou_ctrl_issue: RTL
=====================

// Module: gobou_ctrl_issue
// PURPOSE
//  Transmit end of the gobou ctrl_bus: sequences one fully-connected layer and
//  emits the start/valid/stop stream that the downstream per-stage ctrl delay
//  lines (mac, bias, relu, ...) consume. Splits total_out neurons into groups of
//  BATCH lanes, issues total_in input beats per group, then drains the pipeline.
//  Sits between the layer-level controller (req/done) and the datapath ctrl chain.
// PARAMETERS
//  IMGSIZE  12  width of total_in and in_addr
//  OUTSIZE  10  width of total_out and out_base
//  BATCH    16  output lanes per group (parallel neurons)
//  D_DRAIN  8   idle cycles after each group's stop, >=1 (downstream pipeline depth)
// PORTS
//  clk        in   1        clock, all state on rising edge
//  xrst       in   1        reset, asynchronous, active-low
//  req        in   1        layer request, sampled only in S_IDLE
//  total_in   in   IMGSIZE  input words per neuron, latched on accepted req
//  total_out  in   OUTSIZE  output neurons in layer, latched on accepted req
//  out_ctrl   out  ctrl_bus start/valid/stop stream (ctrl_bus.out modport)
//  in_addr    out  IMGSIZE  input-word index of current valid beat
//  out_base   out  OUTSIZE  first neuron index of current group
//  out_num    out  $clog2(BATCH+1)  live lanes in current group (1..BATCH)
//  busy       out  1        layer in progress
//  done       out  1        one-cycle layer-complete pulse
// BEHAVIOUR
//  Reset (xrst=0, async): state S_IDLE; start/valid/stop/busy/done=0,
//   in_addr=0, out_base=0, out_num=0. Reset mid-layer aborts; no stop issued.
//  All outputs registered. Cycle Cn = cycle after the n-th edge from req sample.
//  FSM: S_IDLE -> S_ISSUE -> S_DRAIN -> (S_ISSUE | S_DONE) -> S_IDLE.
//   S_IDLE: req=1 latches total_in/total_out, group=0. If total_in==0 or
//    total_out==0 -> S_DONE (no valid ever issued); else -> S_ISSUE.
//   S_ISSUE: one beat per cycle, valid=1, in_addr counts 0..total_in-1.
//    start=1 on beat 0 of every group; stop=1 on beat total_in-1.
//    total_in==1: start and stop in same cycle. Then -> S_DRAIN.
//   S_DRAIN: valid/start/stop=0 for exactly D_DRAIN cycles; then next group
//    -> S_ISSUE, or after last group -> S_DONE.
//   S_DONE: done=1 for one cycle, busy still 1; -> S_IDLE (busy=0 next cycle).
//  busy=1 from C1 through the done cycle inclusive.
//  Groups: G = ceil(total_out/BATCH); out_base = g*BATCH; out_num = BATCH,
//   except last group = total_out - (G-1)*BATCH. out_base/out_num stable for
//   whole group incl. its drain; in_addr holds last value during drain.
//  req while busy: ignored, no queueing. req in done cycle: ignored; req
//   accepted in S_IDLE one cycle after done.
//  total_in/total_out changes after accept: no effect until next layer.
//  No wrap: total_out up to 2**OUTSIZE-1; group counter sized accordingly.
// TESTING
//  T1 BATCH=16,D_DRAIN=8, req,total_in=4,total_out=16 -> valid C1-C4, start C1,
//     stop C4, in_addr 0,1,2,3, out_num=16, done C13, busy C1-C13.
//  T2 total_in=3,total_out=40 -> 3 groups, out_base 0/16/32, out_num 16/16/8,
//     starts C1,C12,C23, stops C3,C14,C25, done C34.
//  T3 total_in=1,total_out=5 -> start=stop=valid=1 in C1 only, out_num=5, done C10.
//  T4 total_out=0 (or total_in=0) -> no valid/start/stop, done=1 C1, busy C1 only.
//  T5 req held high through T1 layer -> ignored while busy; second layer accepted
//     in cycle after done deasserts, first valid one cycle later.
//  T6 xrst low during C3 of T2 -> all outputs 0 immediately, no stop; fresh req
//     after release restarts at group 0, in_addr 0.

Source files
------------

// File: rtl/gobou_ctrl_issue_if.sv
// ctrl_bus: start/valid/stop stream between the issue block and the per-stage
// ctrl delay lines.
interface ctrl_bus;
  logic start;
  logic valid;
  logic stop;

  modport out (output start, valid, stop);
  modport in  (input  start, valid, stop);
endinterface

// File: rtl/gobou_ctrl_issue.sv
// gobou_ctrl_issue: sequences one fully-connected layer into BATCH-wide neuron
// groups, issuing total_in beats per group followed by a D_DRAIN idle gap.
module gobou_ctrl_issue #(
  parameter int IMGSIZE = 12,
  parameter int OUTSIZE = 10,
  parameter int BATCH   = 16,
  parameter int D_DRAIN = 8
) (
  input  logic                       clk,
  input  logic                       xrst,
  input  logic                       req,
  input  logic [IMGSIZE-1:0]         total_in,
  input  logic [OUTSIZE-1:0]         total_out,
  ctrl_bus.out                       out_ctrl,
  output logic [IMGSIZE-1:0]         in_addr,
  output logic [OUTSIZE-1:0]         out_base,
  output logic [$clog2(BATCH+1)-1:0] out_num,
  output logic                       busy,
  output logic                       done
);

  localparam int NW = $clog2(BATCH+1);
  localparam int DW = $clog2(D_DRAIN) + 1;
  localparam logic [OUTSIZE-1:0] BATCH_O = OUTSIZE'(BATCH);
  localparam logic [DW-1:0]      DLAST   = DW'(D_DRAIN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             state;
  logic [IMGSIZE-1:0] tin;
  logic [OUTSIZE-1:0] rem;    // neurons not yet covered by earlier groups
  logic [DW-1:0]      dcnt;
  logic               start_q, valid_q, stop_q;

  assign out_ctrl.start = start_q;
  assign out_ctrl.valid = valid_q;
  assign out_ctrl.stop  = stop_q;

  function automatic logic [NW-1:0] lanes(input logic [OUTSIZE-1:0] r);
    if (r >= BATCH_O) return NW'(BATCH);
    else              return NW'(r);
  endfunction

  // Outputs are computed one state ahead so beat 0 appears in the cycle
  // right after the accepting edge.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state    <= S_IDLE;
      tin      <= '0;
      rem      <= '0;
      dcnt     <= '0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      stop_q   <= 1'b0;
      in_addr  <= '0;
      out_base <= '0;
      out_num  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (req) begin
          tin      <= total_in;
          rem      <= total_out;
          out_base <= '0;
          out_num  <= lanes(total_out);
          in_addr  <= '0;
          busy     <= 1'b1;
          if (total_in == '0 || total_out == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state   <= S_ISSUE;
            valid_q <= 1'b1;
            start_q <= 1'b1;
            stop_q  <= (total_in == IMGSIZE'(1));
          end
        end
        S_ISSUE: begin
          if (stop_q) begin
            state   <= S_DRAIN;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            dcnt    <= '0;
          end else begin
            in_addr <= in_addr + IMGSIZE'(1);
            start_q <= 1'b0;
            stop_q  <= (in_addr + IMGSIZE'(2) == tin);
          end
        end
        S_DRAIN: begin
          if (dcnt == DLAST) begin
            if (rem <= BATCH_O) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_ISSUE;
              rem      <= rem - BATCH_O;
              out_base <= out_base + BATCH_O;
              out_num  <= lanes(rem - BATCH_O);
              in_addr  <= '0;
              valid_q  <= 1'b1;
              start_q  <= 1'b1;
              stop_q   <= (tin == IMGSIZE'(1));
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
